// File: rtl/range_pkg.sv
// Shared types for the range session arbiter: FSM states, result record and default sizes.
package range_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int ID_W      = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] range;
    logic [DEF_WIDTH-1:0] min;
    logic [DEF_WIDTH-1:0] max;
    logic [ID_W-1:0]      id;
    logic                 error;
  } range_result_t;
endpackage

// File: rtl/range_core.sv
// Min/max tracker reused by every session; outputs already fold in this cycle's sample.
// Zero latency on outputs, state updates on the clock; no backpressure of its own.
module range_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             upd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] range
);
  logic [WIDTH-1:0] min_q, max_q;

  // Strict compares so equal samples leave the stored extremes untouched.
  always_comb begin
    min = min_q;
    max = max_q;
    if (load) begin
      min = data;
      max = data;
    end else if (upd) begin
      if (data < min_q) min = data;
      if (data > max_q) max = data;
    end
    range = max - min;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min;
      max_q <= max;
    end
  end
endmodule

// File: rtl/range_session_arbiter.sv
// Round-robin owner of one min/max tracker; one session per grant, result held until res_ready.
// req->grant 1 cycle, last sample->res_valid 1 cycle; only the owner sees req_ready, REPORT stalls on res_ready.
module range_session_arbiter
  import range_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int MAXLEN  = 255,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         grant,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_range,
  output logic [WIDTH-1:0]        res_min,
  output logic [WIDTH-1:0]        res_max,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_error
);
  localparam int GW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAXLEN + 1);
  localparam int IDL_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [GW-1:0]     rr_ptr, g_id, pick_id;
  logic              pick_vld;
  int                rr_idx;
  logic [CNT_W-1:0]  cnt;
  logic [IDL_W-1:0]  idle;
  logic              acc, acc_last, has_data, drop, fin, ovf, tmo;
  logic [WIDTH-1:0]  g_data, c_min, c_max, c_range;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    rr_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_idx = (int'(rr_ptr) + k) % NREQ;
      if (req[rr_idx]) begin
        pick_vld = 1'b1;
        pick_id  = GW'(rr_idx);
      end
    end
  end

  // grant is only non-zero in RUN, so it doubles as the ready vector.
  assign req_ready = grant;
  assign g_data    = req_data[g_id*WIDTH +: WIDTH];
  assign acc       = |(req_valid & grant);
  assign acc_last  = |(req_valid & req_last & grant);
  assign has_data  = acc | (cnt != '0);
  assign drop      = !req[g_id];
  assign fin       = acc_last && !drop;
  assign ovf       = acc && !acc_last && (cnt == CNT_W'(MAXLEN - 1));
  assign tmo       = !acc && (idle == IDL_W'(TIMEOUT - 1));

  range_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (acc && (cnt == '0)),
    .upd   (acc && (cnt != '0)),
    .data  (g_data),
    .min   (c_min),
    .max   (c_max),
    .range (c_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g_id      <= '0;
      grant     <= '0;
      cnt       <= '0;
      idle      <= '0;
      res_valid <= 1'b0;
      res_range <= '0;
      res_min   <= '0;
      res_max   <= '0;
      res_id    <= '0;
      res_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            g_id  <= pick_id;
            grant <= NREQ'(1) << pick_id;
            cnt   <= '0;
            idle  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (acc) begin
            cnt  <= cnt + 1'b1;
            idle <= '0;
          end else begin
            idle <= idle + 1'b1;
          end
          if (drop || fin || ovf || tmo) begin
            state     <= REPORT;
            grant     <= '0;
            res_valid <= 1'b1;
            res_id    <= g_id;
            res_error <= !fin;
            res_range <= fin ? c_range : '0;
            res_min   <= has_data ? c_min : '0;
            res_max   <= has_data ? c_max : '0;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            rr_ptr    <= (g_id == GW'(NREQ - 1)) ? '0 : g_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed sessions checked against a queue-based session model plus literal expectations.
module tb_range_session_arbiter;
  import range_pkg::*;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int MAXLEN  = 3;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [WIDTH-1:0]      res_range, res_min, res_max;
  logic [ID_W-1:0]       res_id;
  logic                  res_error;

  int n_pass = 0;
  int n_tot  = 0;

  range_session_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .res_valid(res_valid),
    .res_ready(res_ready), .res_range(res_range), .res_min(res_min), .res_max(res_max),
    .res_id(res_id), .res_error(res_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Session model: who owns the tracker, which samples it has taken, what the result must be.
  int            m_phase, m_ptr, m_owner, m_idle, m_mn, m_mx;
  int            m_samples[$];
  bit            m_acc, m_lst, m_drop, m_fin, m_ovf, m_to;
  range_result_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_idle = 0;
      m_samples.delete();
      m_res = '0;
    end else begin
      case (m_phase)
        0: begin
          for (int k = 0; k < NREQ; k++)
            if (m_phase == 0 && req[(m_ptr + k) % NREQ]) begin
              m_owner = (m_ptr + k) % NREQ;
              m_phase = 1;
            end
          m_samples.delete();
          m_idle = 0;
        end
        1: begin
          m_acc  = req_valid[m_owner];
          m_lst  = req_last[m_owner];
          if (m_acc) m_samples.push_back(int'(req_data[m_owner*WIDTH +: WIDTH]));
          m_drop = !req[m_owner];
          m_fin  = m_acc && m_lst && !m_drop;
          m_ovf  = m_acc && !m_lst && m_samples.size() == MAXLEN;
          m_to   = !m_acc && m_idle == TIMEOUT - 1;
          m_idle = m_acc ? 0 : m_idle + 1;
          if (m_drop || m_fin || m_ovf || m_to) begin
            m_mn = 0; m_mx = 0;
            if (m_samples.size() > 0) begin
              m_mn = 255;
              foreach (m_samples[j]) begin
                if (m_samples[j] < m_mn) m_mn = m_samples[j];
                if (m_samples[j] > m_mx) m_mx = m_samples[j];
              end
            end
            m_res.error = !m_fin;
            m_res.min   = 8'(m_mn);
            m_res.max   = 8'(m_mx);
            m_res.range = m_fin ? 8'(m_mx - m_mn) : 8'd0;
            m_res.id    = ID_W'(m_owner);
            m_phase     = 2;
          end
        end
        default: begin
          if (res_ready) begin
            m_phase = 0;
            m_ptr   = (m_owner + 1) % NREQ;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant", int'(grant), (m_phase == 1) ? (1 << m_owner) : 0);
      chk("req_ready", int'(req_ready), (m_phase == 1) ? (1 << m_owner) : 0);
      chk("res_valid", int'(res_valid), (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("res_range", int'(res_range), int'(m_res.range));
        chk("res_min", int'(res_min), int'(m_res.min));
        chk("res_max", int'(res_max), int'(m_res.max));
        chk("res_id", int'(res_id), int'(m_res.id));
        chk("res_error", int'(res_error), int'(m_res.error));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i);
    for (int c = 0; c < 20 && grant != NREQ'(1 << i); c++) tick();
    chk("grant_wait", int'(grant), 1 << i);
  endtask

  task automatic wait_res();
    for (int c = 0; c < 40 && !res_valid; c++) tick();
    chk("res_wait", int'(res_valid), 1);
  endtask

  task automatic send(input int i, input int d, input bit l);
    req_valid[i] = 1'b1;
    req_data[i*WIDTH +: WIDTH] = d[7:0];
    req_last[i] = l;
    tick();
    req_valid[i] = 1'b0;
    req_last[i] = 1'b0;
  endtask

  task automatic handshake(input logic [NREQ-1:0] req_after);
    res_ready = 1'b1;
    req = req_after;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic chk_res(input string nm, input int rg, input int mn, input int mx, input int id, input int er);
    chk({nm, "_range"}, int'(res_range), rg);
    chk({nm, "_min"}, int'(res_min), mn);
    chk({nm, "_max"}, int'(res_max), mx);
    chk({nm, "_id"}, int'(res_id), id);
    chk({nm, "_err"}, int'(res_error), er);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, int'(grant), 0);
    chk({nm, "_ready"}, int'(req_ready), 0);
    chk({nm, "_valid"}, int'(res_valid), 0);
    chk_res(nm, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk_zero("reset");
    tick(2);
    rst_n = 1'b1;
    tick();

    // Session 1: id 1 alone, noise from non-granted requester 3.
    req_valid[3] = 1'b1;
    req_data[3*WIDTH +: WIDTH] = 8'd1;
    req = 4'b0010;
    tick();
    chk("t1_grant_latency", int'(grant), 2);
    send(1, 20, 0);
    send(1, 5, 0);
    send(1, 90, 1);
    chk("t1_res_latency", int'(res_valid), 1);
    chk_res("t1", 85, 5, 90, 1, 0);
    req_valid[3] = 1'b0;
    handshake(4'b0000);

    // Round robin from a fresh reset with all requesters held.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_grant(s % NREQ);
      send(s % NREQ, 10 * s + 3, 1);
      wait_res();
      chk("t2_id", int'(res_id), s % NREQ);
      handshake((s == 4) ? 4'b0000 : 4'b1111);
    end

    // Requester drop after one sample.
    req = 4'b0100;
    wait_grant(2);
    send(2, 7, 0);
    req = 4'b0000;
    wait_res();
    chk_res("t3", 0, 7, 7, 2, 1);
    handshake(4'b0000);

    // Stall timeout with no samples at all.
    req = 4'b0001;
    wait_grant(0);
    tick(TIMEOUT - 1);
    chk("t4_before_timeout", int'(res_valid), 0);
    tick();
    chk("t4_timeout", int'(res_valid), 1);
    chk_res("t4a", 0, 0, 0, 0, 1);
    handshake(4'b0000);

    // MAXLEN samples without last.
    req = 4'b1000;
    wait_grant(3);
    send(3, 22, 0);
    send(3, 11, 0);
    send(3, 33, 0);
    chk("t4b_valid", int'(res_valid), 1);
    chk_res("t4b", 0, 11, 33, 3, 1);
    handshake(4'b0000);

    // Result held under backpressure while another requester waits.
    req = 4'b0010;
    wait_grant(1);
    send(1, 40, 0);
    send(1, 60, 1);
    req = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_hold_grant", int'(grant), 0);
      chk("t5_hold_valid", int'(res_valid), 1);
      chk_res("t5_hold", 20, 40, 60, 1, 0);
    end
    handshake(4'b0100);
    wait_grant(2);
    send(2, 9, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("t5_midrun_reset");
    req = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single sample and ties.
    req = 4'b0001;
    wait_grant(0);
    send(0, 200, 1);
    chk_res("t6_single", 0, 200, 200, 0, 0);
    handshake(4'b0010);
    wait_grant(1);
    send(1, 50, 0);
    send(1, 50, 0);
    send(1, 50, 1);
    chk_res("t6_ties", 0, 50, 50, 1, 0);
    handshake(4'b0000);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
